// File: rtl/frame_align.sv
// ---------------------------------------------------------------------------
// frame_align
//   Receive-side frame aligner. Hunts the raw byte stream for the 6-byte FAS,
//   runs a HUNT/PRESYNC/SYNC state machine and tags every byte with its
//   row/column position and a FAS flag. The frame is 4 rows x (COL_MAX+1)
//   columns. All outputs are registered: one cycle of latency.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_data[7:0]     raw line byte
//   i_frame_data_valid    byte qualifier
//   o_frame_data[7:0]     byte, delayed 1 cycle (every cycle)
//   o_frame_data_valid    valid, delayed 1 cycle (every cycle)
//   o_frame_data_fas      byte sits at row 0 cols 0-5 while PRESYNC/SYNC
//   o_row_cnt[1:0]        row of the output byte
//   o_col_cnt[10:0]       column of the output byte
//   o_in_frame            aligner is in SYNC
//   o_lof                 loss of frame
//
// Optional build macro FRAME_ALIGN_STATS_EN adds:
//   o_fas_err_cnt[15:0]   FAS misses at the expected position while in SYNC
//   o_lof_cnt[15:0]       SYNC->HUNT transitions
//   Both saturate at 16'hFFFF and clear on reset.
// ---------------------------------------------------------------------------
module frame_align #(
    parameter logic [47:0] FAS_WORD   = 48'hF6F6F6282828,
    parameter int          COL_MAX    = 1040,
    parameter int          LOF_THRESH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic        o_frame_data_fas,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_in_frame,
`ifdef FRAME_ALIGN_STATS_EN
    output logic [15:0] o_fas_err_cnt,
    output logic [15:0] o_lof_cnt,
`endif
    output logic        o_lof
);

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    localparam logic [10:0] COL_LAST  = 11'(COL_MAX);
    localparam logic [3:0]  MISS_LAST = 4'(LOF_THRESH - 1);
    localparam logic [10:0] FAS_COL   = 11'd5;   // column of the last FAS byte

    state_t      state_q, state_d;
    logic [39:0] shreg_q, shreg_d;
    logic [1:0]  row_q, row_d;
    logic [10:0] col_q, col_d;
    logic        fas_q, fas_d;
    logic        lof_q, lof_d;
    logic [3:0]  miss_q, miss_d;
    logic [7:0]  data_q;
    logic        valid_q;

    logic        match;
    logic        exp_pos;
    logic [1:0]  row_nxt;
    logic [10:0] col_nxt;

    always_comb begin
        match   = ({shreg_q, i_frame_data} == FAS_WORD);
        col_nxt = (col_q == COL_LAST) ? 11'd0 : col_q + 11'd1;
        row_nxt = (col_q == COL_LAST) ? row_q + 2'd1 : row_q;
        exp_pos = (row_nxt == 2'd0) && (col_nxt == FAS_COL);

        state_d = state_q;
        shreg_d = shreg_q;
        row_d   = row_q;
        col_d   = col_q;
        fas_d   = fas_q;
        lof_d   = lof_q;
        miss_d  = miss_q;

        if (i_frame_data_valid) begin
            shreg_d = {shreg_q[31:0], i_frame_data};
            case (state_q)
                HUNT: begin
                    row_d = 2'd0;
                    col_d = 11'd0;
                    // The detecting byte is the last FAS byte: it lands on col 5.
                    if (match) begin
                        state_d = PRESYNC;
                        col_d   = FAS_COL;
                    end
                end
                PRESYNC: begin
                    row_d = row_nxt;
                    col_d = col_nxt;
                    if (exp_pos) begin
                        if (match) begin
                            state_d = SYNC;
                            lof_d   = 1'b0;
                            miss_d  = 4'd0;
                        end else begin
                            state_d = HUNT;
                            row_d   = 2'd0;
                            col_d   = 11'd0;
                        end
                    end
                end
                SYNC: begin
                    // Flywheel: position keeps running through FAS misses.
                    row_d = row_nxt;
                    col_d = col_nxt;
                    if (exp_pos) begin
                        if (match) begin
                            miss_d = 4'd0;
                        end else if (miss_q == MISS_LAST) begin
                            state_d = HUNT;
                            lof_d   = 1'b1;
                            miss_d  = 4'd0;
                            row_d   = 2'd0;
                            col_d   = 11'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    row_d   = 2'd0;
                    col_d   = 11'd0;
                end
            endcase
            fas_d = (state_d != HUNT) && (row_d == 2'd0) && (col_d <= FAS_COL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HUNT;
            shreg_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            fas_q   <= 1'b0;
            lof_q   <= 1'b1;
            miss_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fas_q   <= fas_d;
            lof_q   <= lof_d;
            miss_q  <= miss_d;
            data_q  <= i_frame_data;
            valid_q <= i_frame_data_valid;
        end
    end

`ifdef FRAME_ALIGN_STATS_EN
    logic [15:0] err_cnt_q, lof_cnt_q;
    logic        sync_miss, sync_lost;

    always_comb begin
        sync_miss = i_frame_data_valid && (state_q == SYNC) && exp_pos && !match;
        sync_lost = (state_q == SYNC) && (state_d == HUNT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q <= '0;
            lof_cnt_q <= '0;
        end else begin
            if (sync_miss && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
            if (sync_lost && (lof_cnt_q != 16'hFFFF)) lof_cnt_q <= lof_cnt_q + 16'd1;
        end
    end

    assign o_fas_err_cnt = err_cnt_q;
    assign o_lof_cnt     = lof_cnt_q;
`endif

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = valid_q;
    assign o_frame_data_fas   = fas_q;
    assign o_row_cnt          = row_q;
    assign o_col_cnt          = col_q;
    assign o_in_frame         = (state_q == SYNC);
    assign o_lof              = lof_q;

endmodule

// File: tb/tb_frame_align.sv
// ---------------------------------------------------------------------------
// tb_frame_align
//   Scoreboard bench for frame_align. Every driven cycle pushes the expected
//   registered output into a queue; a monitor pops and compares one entry
//   per clock, 1 time unit after the rising edge. A few directed checks of
//   state flags are made from the stimulus process at chosen points.
// ---------------------------------------------------------------------------
module tb_frame_align;

    localparam logic [47:0] FAS  = 48'hF6F6F6282828;
    localparam logic [47:0] BAD  = 48'h00F6F6282828;
    localparam int          NCOL = 1041;
    localparam int          FLEN = 4 * NCOL;

    typedef struct packed {
        logic [7:0]  data;
        logic        valid;
        logic        fas;
        logic [1:0]  row;
        logic [10:0] col;
        logic        inf;
        logic        lof;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        vin = 1'b0;
    logic [7:0]  dout;
    logic        vout, fas_o, inf_o, lof_o;
    logic [1:0]  row_o;
    logic [10:0] col_o;
`ifdef FRAME_ALIGN_STATS_EN
    logic [15:0] err_cnt_o, lof_cnt_o;
`endif

    frame_align dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_frame_data       (din),
        .i_frame_data_valid (vin),
        .o_frame_data       (dout),
        .o_frame_data_valid (vout),
        .o_frame_data_fas   (fas_o),
        .o_row_cnt          (row_o),
        .o_col_cnt          (col_o),
        .o_in_frame         (inf_o),
`ifdef FRAME_ALIGN_STATS_EN
        .o_fas_err_cnt      (err_cnt_o),
        .o_lof_cnt          (lof_cnt_o),
`endif
        .o_lof              (lof_o)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_byte = 0;
    out_t exp_q[$];

    // Reference model: linear frame position instead of row/col counters.
    int          ms   = 0;      // 0 hunt, 1 presync, 2 sync
    logic [39:0] msh  = '0;
    int          mpos = 0;
    int          mmiss = 0;
    logic        mlof = 1'b1;
    int          merrs = 0;
    int          mlofs = 0;

    function automatic out_t model_step(input logic [7:0] d, input logic v, input logic r);
        out_t o;
        logic m;
        if (r) begin
            ms = 0; msh = '0; mpos = 0; mmiss = 0; mlof = 1'b1; merrs = 0; mlofs = 0;
            o = '{data: 8'h00, valid: 1'b0, fas: 1'b0, row: 2'd0, col: 11'd0, inf: 1'b0, lof: 1'b1};
            return o;
        end
        if (v) begin
            m   = ({msh, d} == FAS);
            msh = {msh[31:0], d};
            if (ms == 0) begin
                if (m) begin ms = 1; mpos = 5; end else mpos = 0;
            end else begin
                mpos = (mpos + 1) % FLEN;
                if (mpos == 5) begin
                    if (ms == 1) begin
                        if (m) begin ms = 2; mlof = 1'b0; mmiss = 0; end
                        else begin ms = 0; mpos = 0; end
                    end else if (m) begin
                        mmiss = 0;
                    end else begin
                        mmiss++; merrs++;
                        if (mmiss == 5) begin
                            ms = 0; mlof = 1'b1; mmiss = 0; mpos = 0; mlofs++;
                        end
                    end
                end
            end
        end
        o.data  = d;
        o.valid = v;
        o.fas   = (ms != 0) && (mpos <= 5);
        o.row   = 2'(mpos / NCOL);
        o.col   = 11'(mpos % NCOL);
        o.inf   = (ms == 2);
        o.lof   = mlof;
        return o;
    endfunction

    // Monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        out_t e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{data: dout, valid: vout, fas: fas_o, row: row_o, col: col_o, inf: inf_o, lof: lof_o};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL out[%0d]: got d=%h v=%b fas=%b r=%0d c=%0d inf=%b lof=%b, want d=%h v=%b fas=%b r=%0d c=%0d inf=%b lof=%b",
                             n_byte, g.data, g.valid, g.fas, g.row, g.col, g.inf, g.lof,
                             e.data, e.valid, e.fas, e.row, e.col, e.inf, e.lof);
            end
            n_byte++;
        end
    end

    task automatic drive(input logic [7:0] d, input logic v, input logic r);
        @(negedge clk);
        rst = r; din = d; vin = v;
        exp_q.push_back(model_step(d, v, r));
    endtask

    // Directed check of the outputs produced by the most recent drive().
    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pay();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (b == 8'hF6 || b == 8'h28) b = 8'($urandom_range(0, 255));
        return b;
    endfunction

    int gcnt = 0;

    // Sends nbytes of a frame whose first six bytes are fas. With gap set,
    // every third cycle is an invalid cycle carrying an FAS-like byte.
    task automatic send_frame(input logic [47:0] fas, input int nbytes, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            if (gap && (gcnt % 3 == 2)) begin
                drive(8'hF6, 1'b0, 1'b0);
                gcnt++;
            end
            b = (i < 6) ? fas[47 - 8*i -: 8] : pay();
            drive(b, 1'b1, 1'b0);
            gcnt++;
        end
    endtask

    initial begin
        // Reset
        repeat (3) drive(8'hAA, 1'b1, 1'b1);
        settle();
        chk("reset lof", lof_o, 1);
        chk("reset in_frame", inf_o, 0);
        chk("reset row", row_o, 0);
        chk("reset col", col_o, 0);
        chk("reset valid", vout, 0);

        // Three clean frames: PRESYNC in frame 1, SYNC in frame 2
        for (int f = 0; f < 3; f++) send_frame(FAS, FLEN, 1'b0);
        settle();
        chk("clean in_frame", inf_o, 1);
        chk("clean lof", lof_o, 0);
        chk("clean last row", row_o, 3);
        chk("clean last col", col_o, 1040);

        // Junk from HUNT, then aligned frames
        drive(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 2000; i++) drive(pay(), 1'b1, 1'b0);
        settle();
        chk("junk in_frame", inf_o, 0);
        chk("junk lof", lof_o, 1);
        for (int f = 0; f < 2; f++) send_frame(FAS, FLEN, 1'b0);
        settle();
        chk("post-junk in_frame", inf_o, 1);

        // Four bad FAS frames: no LOF
        for (int f = 0; f < 4; f++) send_frame(BAD, FLEN, 1'b0);
        settle();
        chk("4 miss in_frame", inf_o, 1);
        chk("4 miss lof", lof_o, 0);
`ifdef FRAME_ALIGN_STATS_EN
        chk("4 miss err_cnt", err_cnt_o, 4);
`endif

        // Good frame restores, reset at row 2 col 500
        send_frame(FAS, 2 * NCOL + 501, 1'b0);
        settle();
        chk("pre-reset row", row_o, 2);
        chk("pre-reset col", col_o, 500);
        chk("pre-reset in_frame", inf_o, 1);
        drive(8'h5A, 1'b1, 1'b1);
        settle();
        chk("midreset lof", lof_o, 1);
        chk("midreset in_frame", inf_o, 0);
        chk("midreset fas", fas_o, 0);
`ifdef FRAME_ALIGN_STATS_EN
        chk("midreset err_cnt", err_cnt_o, 0);
        chk("midreset lof_cnt", lof_cnt_o, 0);
`endif

        // Realign, then five bad frames: LOF
        for (int f = 0; f < 2; f++) send_frame(FAS, FLEN, 1'b0);
        for (int f = 0; f < 5; f++) send_frame(BAD, FLEN, 1'b0);
        settle();
        chk("lof lof", lof_o, 1);
        chk("lof in_frame", inf_o, 0);
        chk("lof row held 0", row_o, 0);
`ifdef FRAME_ALIGN_STATS_EN
        chk("lof err_cnt", err_cnt_o, 5);
        chk("lof lof_cnt", lof_cnt_o, 1);
`endif

        // Realignment with valid dropped every third cycle
        for (int f = 0; f < 2; f++) send_frame(FAS, FLEN, 1'b1);
        settle();
        chk("gap in_frame", inf_o, 1);
        chk("gap lof", lof_o, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
